// File: rtl/gb_pkg.sv
// gb_pkg: shared timer state type, register addresses and read masks
package gb_pkg;
  typedef enum logic [1:0] {TimerNormal, TimerOverflow, TimerReload} timer_state_e;
  localparam logic [15:0] ADDR_DIV = 16'hFF04;
  localparam logic [15:0] ADDR_TIMA = 16'hFF05;
  localparam logic [15:0] ADDR_TMA = 16'hFF06;
  localparam logic [15:0] ADDR_TAC = 16'hFF07;
  localparam logic [7:0] TAC_READ_MASK = 8'hF8;
endpackage

// File: rtl/timer.sv
// timer: DIV/TIMA/TMA/TAC bus responder with delayed TIMA reload and one-clock irq
module timer
  import gb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  t_cycle,
  input  logic [15:0] bus_addr,
  input  logic        bus_enable,
  input  logic        bus_write,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  output logic        bus_selected,
  output logic        timer_irq
);
  logic [15:0] counter_q, counter_d;
  logic [7:0] tima_q, tima_d, tma_q, tma_d;
  logic [2:0] tac_q, tac_d;
  logic [1:0] phase_q, phase_d;
  logic tick_q, tick, inc, irq_d;
  logic wr, wr_div, wr_tima, wr_tma, wr_tac;
  timer_state_e state_q, state_d;
  assign bus_selected = bus_enable && bus_addr[15:2] == ADDR_DIV[15:2];
  assign wr = bus_selected && bus_write && t_cycle == 2'd3;
  assign wr_div = wr && bus_addr == ADDR_DIV;
  assign wr_tima = wr && bus_addr == ADDR_TIMA;
  assign wr_tma = wr && bus_addr == ADDR_TMA;
  assign wr_tac = wr && bus_addr == ADDR_TAC;
  assign bus_data_out = !bus_selected ? 8'hFF :
                        bus_addr[1:0] == 2'd0 ? counter_q[15:8] :
                        bus_addr[1:0] == 2'd1 ? tima_q :
                        bus_addr[1:0] == 2'd2 ? tma_q : (TAC_READ_MASK | {5'd0, tac_q});
  assign tick = tac_q[2] && (tac_q[1:0] == 2'd0 ? counter_q[9] :
                             tac_q[1:0] == 2'd1 ? counter_q[3] :
                             tac_q[1:0] == 2'd2 ? counter_q[5] : counter_q[7]);
  // falling tick edges also come from DIV/TAC writes, matching the original hardware glitch
  assign inc = tick_q && !tick;
  always_comb begin
    counter_d = wr_div ? 16'd0 : counter_q + 16'd1;
    tac_d = wr_tac ? bus_data_in[2:0] : tac_q;
    tma_d = wr_tma ? bus_data_in : tma_q;
    tima_d = tima_q;
    state_d = state_q;
    phase_d = state_q == TimerNormal ? 2'd0 : phase_q + 2'd1;
    irq_d = 1'b0;
    case (state_q)
      TimerNormal: begin
        if (wr_tima) tima_d = bus_data_in;
        else if (inc && tima_q == 8'hFF) begin
          tima_d = 8'h00;
          state_d = TimerOverflow;
        end else if (inc) tima_d = tima_q + 8'd1;
      end
      TimerOverflow: begin
        if (wr_tima) begin
          tima_d = bus_data_in;
          state_d = TimerNormal;
          phase_d = 2'd0;
        end else if (phase_q == 2'd3) begin
          tima_d = tma_q;
          irq_d = 1'b1;
          state_d = TimerReload;
          phase_d = 2'd0;
        end
      end
      default: begin
        if (wr_tma) tima_d = bus_data_in;
        if (phase_q == 2'd3) begin
          state_d = TimerNormal;
          phase_d = 2'd0;
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_q <= '0;
      tima_q <= '0;
      tma_q <= '0;
      tac_q <= '0;
      tick_q <= 1'b0;
      state_q <= TimerNormal;
      phase_q <= '0;
      timer_irq <= 1'b0;
    end else begin
      counter_q <= counter_d;
      tima_q <= tima_d;
      tma_q <= tma_d;
      tac_q <= tac_d;
      tick_q <= tick;
      state_q <= state_d;
      phase_q <= phase_d;
      timer_irq <= irq_d;
    end
  end
endmodule

// File: tb/tb_timer.sv
// tb_timer: directed scenarios plus random bus traffic against a cycle-level reference model
module tb_timer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] t_cycle = 2'd0;
  logic [15:0] bus_addr = 16'h0000;
  logic bus_enable = 1'b0;
  logic bus_write = 1'b0;
  logic [7:0] bus_data_in = 8'h00;
  logic [7:0] bus_data_out;
  logic bus_selected;
  logic timer_irq;
  int n_checks = 0;
  int n_errors = 0;
  logic mon_en = 1'b0;
  timer dut (
    .clk(clk), .reset(reset), .t_cycle(t_cycle), .bus_addr(bus_addr),
    .bus_enable(bus_enable), .bus_write(bus_write), .bus_data_in(bus_data_in),
    .bus_data_out(bus_data_out), .bus_selected(bus_selected), .timer_irq(timer_irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // reference model: m_since counts clocks since TIMA wrapped, -1 when idle
  logic [15:0] m_cnt;
  logic [7:0] m_tima, m_tma, old_tma;
  logic [2:0] m_tac;
  logic m_tick, m_irq, tk, fall, hit, w_tima, w_tma;
  int m_since;
  int sel_bit [4] = '{9, 3, 5, 7};
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_tick = 0; m_irq = 0; m_since = -1;
    end else begin
      hit = bus_enable && bus_write && t_cycle == 2'd3 && bus_addr >= 16'hFF04 && bus_addr <= 16'hFF07;
      w_tima = hit && bus_addr == 16'hFF05;
      w_tma = hit && bus_addr == 16'hFF06;
      tk = m_tac[2] && m_cnt[sel_bit[m_tac[1:0]]];
      fall = m_tick && !tk;
      old_tma = m_tma;
      m_tick = tk;
      m_irq = 0;
      m_cnt = (hit && bus_addr == 16'hFF04) ? 16'd0 : m_cnt + 16'd1;
      if (hit && bus_addr == 16'hFF07) m_tac = bus_data_in[2:0];
      if (w_tma) m_tma = bus_data_in;
      if (m_since < 0) begin
        if (w_tima) m_tima = bus_data_in;
        else if (fall && m_tima == 8'hFF) begin m_tima = 0; m_since = 0; end
        else if (fall) m_tima = m_tima + 1;
      end else if (m_since < 4) begin
        if (w_tima) begin m_tima = bus_data_in; m_since = -1; end
        else if (m_since == 3) begin m_tima = old_tma; m_irq = 1; m_since = 4; end
        else m_since++;
      end else begin
        if (w_tma) m_tima = bus_data_in;
        m_since = (m_since == 7) ? -1 : m_since + 1;
      end
    end
  end
  function automatic logic exp_sel();
    return bus_enable && bus_addr >= 16'hFF04 && bus_addr <= 16'hFF07;
  endfunction
  function automatic logic [7:0] exp_rd();
    if (!exp_sel()) return 8'hFF;
    case (bus_addr)
      16'hFF04: return m_cnt[15:8];
      16'hFF05: return m_tima;
      16'hFF06: return m_tma;
      default: return {5'b11111, m_tac};
    endcase
  endfunction
  always @(negedge clk) if (mon_en) begin
    chk("sel", {15'd0, bus_selected}, {15'd0, exp_sel()});
    chk("rd", {8'd0, bus_data_out}, {8'd0, exp_rd()});
    chk("irq", {15'd0, timer_irq}, {15'd0, m_irq});
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus_addr = a; bus_data_in = d; bus_enable = 1; bus_write = 1; t_cycle = 2'd3;
    step(1);
    bus_enable = 0; bus_write = 0; t_cycle = 2'd0;
  endtask
  task automatic rd(input logic [15:0] a, output logic [7:0] v);
    bus_addr = a; bus_enable = 1; bus_write = 0;
    #1;
    v = bus_data_out;
  endtask
  task automatic wait_tima(input logic want_zero, input int limit, output int n);
    logic [7:0] v;
    n = 0;
    rd(16'hFF05, v);
    while (((v == 0) != want_zero) && n < limit) begin step(1); rd(16'hFF05, v); n++; end
    chk(want_zero ? "wait_zero" : "wait_nonzero", {15'd0, n < limit}, 16'd1);
  endtask
  initial begin
    logic [7:0] v;
    int n, irqs;
    step(3);
    mon_en = 1;
    rd(16'hFF04, v); chk("rst_div", {8'd0, v}, 16'h00);
    rd(16'hFF05, v); chk("rst_tima", {8'd0, v}, 16'h00);
    rd(16'hFF06, v); chk("rst_tma", {8'd0, v}, 16'h00);
    rd(16'hFF07, v); chk("rst_tac", {8'd0, v}, 16'hF8);
    bus_enable = 0; #1;
    chk("unsel", {8'd0, bus_data_out}, 16'hFF);
    reset = 0;
    step(256);
    rd(16'hFF04, v); chk("div256", {8'd0, v}, 16'h01);
    wr(16'hFF04, 8'h5A);
    rd(16'hFF04, v); chk("div_clr", {8'd0, v}, 16'h00);
    wr(16'hFF07, 8'h05);
    wr(16'hFF05, 8'h00);
    step(160);
    rd(16'hFF05, v); chk("tima160", {8'd0, v}, 16'h0A);
    rd(16'hFF07, v); chk("tac_rd", {8'd0, v}, 16'hFD);
    // overflow and reload
    wr(16'hFF06, 8'hAB);
    wr(16'hFF05, 8'hFF);
    wait_tima(1, 40, n);
    n = 0; irqs = 0;
    rd(16'hFF05, v);
    while (v == 0 && n < 10) begin irqs += int'(timer_irq); step(1); rd(16'hFF05, v); n++; end
    chk("ovf_len", n[15:0], 16'd4);
    chk("ovf_irq_early", irqs[15:0], 16'd0);
    chk("reload_val", {8'd0, v}, 16'hAB);
    chk("irq_hi", {15'd0, timer_irq}, 16'd1);
    step(1);
    chk("irq_lo", {15'd0, timer_irq}, 16'd0);
    // cancel during overflow
    step(10);
    wr(16'hFF05, 8'hFF);
    wait_tima(1, 40, n);
    wr(16'hFF05, 8'h42);
    rd(16'hFF05, v); chk("cancel_val", {8'd0, v}, 16'h42);
    irqs = 0;
    for (int i = 0; i < 8; i++) begin irqs += int'(timer_irq); step(1); end
    chk("cancel_irq", irqs[15:0], 16'd0);
    // writes during reload
    wr(16'hFF05, 8'hFF);
    wait_tima(1, 40, n);
    wait_tima(0, 10, n);
    wr(16'hFF05, 8'h42);
    rd(16'hFF05, v); chk("reload_tima_wr", {8'd0, v}, 16'hAB);
    wr(16'hFF06, 8'h77);
    rd(16'hFF05, v); chk("reload_tma_wr", {8'd0, v}, 16'h77);
    // DIV write while the selected counter bit is high
    step(10);
    n = 0;
    while (m_cnt[3:0] != 4'd8 && n < 40) begin step(1); n++; end
    chk("glitch_align", {15'd0, n < 40}, 16'd1);
    wr(16'hFF05, 8'h10);
    wr(16'hFF04, 8'h00);
    rd(16'hFF05, v); chk("glitch_pre", {8'd0, v}, 16'h10);
    step(1);
    rd(16'hFF05, v); chk("glitch_inc", {8'd0, v}, 16'h11);
    // reset in the middle of overflow
    wr(16'hFF05, 8'hFF);
    wait_tima(1, 40, n);
    step(1);
    reset = 1;
    #1;
    rd(16'hFF04, v); chk("abort_div", {8'd0, v}, 16'h00);
    rd(16'hFF05, v); chk("abort_tima", {8'd0, v}, 16'h00);
    rd(16'hFF06, v); chk("abort_tma", {8'd0, v}, 16'h00);
    rd(16'hFF07, v); chk("abort_tac", {8'd0, v}, 16'hF8);
    step(2);
    reset = 0;
    irqs = 0;
    for (int i = 0; i < 12; i++) begin irqs += int'(timer_irq); step(1); end
    chk("abort_irq", irqs[15:0], 16'd0);
    rd(16'hFF05, v); chk("abort_tima_after", {8'd0, v}, 16'h00);
    // random traffic, checked every cycle by the monitor
    for (int i = 0; i < 4000; i++) begin
      bus_addr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'hFF03 + 16'($urandom_range(0, 5));
      bus_enable = $urandom_range(0, 7) != 0;
      bus_write = $urandom_range(0, 2) == 0;
      t_cycle = 2'($urandom_range(0, 3));
      bus_data_in = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      if (bus_addr == 16'hFF07 && $urandom_range(0, 1) == 0) bus_data_in[2] = 1'b1;
      step(1);
    end
    bus_enable = 0; bus_write = 0;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/timer.md
# timer

Memory-mapped DIV/TIMA/TMA/TAC timer peripheral: the responder side of the CPU system bus at 0xFF04–0xFF07. It decodes CPU bus cycles, commits writes on the CPU's T-cycle 3, and returns read data combinationally. It runs a 16-bit system counter at the clock rate and raises a one-clock interrupt request when TIMA overflows.

## Interface
- No parameters; register addresses are fixed constants.
- `clk` input 1: system clock, 4 MHz, one T-cycle per edge.
- `reset` input 1: asynchronous, active-high reset.
- `t_cycle` input 2: the CPU's current T-cycle index, 0–3.
- `bus_addr` input 16: the CPU's `mem_addr`.
- `bus_enable` input 1: the CPU's `mem_enable`.
- `bus_write` input 1: the CPU's `mem_write`.
- `bus_data_in` input 8: the CPU's `mem_data_out` (write data).
- `bus_data_out` output 8: read data. Valid while `bus_selected`; 0xFF otherwise.
- `bus_selected` output 1: `bus_enable` AND `bus_addr` in 0xFF04–0xFF07.
- `timer_irq` output 1: registered one-clock interrupt-request pulse.

## Operation
- **State:**
  - `counter[15:0]` increments by 1 every clk and wraps at 0xFFFF→0x0000.
  - 8-bit registers `tima`, `tma`, `tac[2:0]`.
  - `state` is one of TimerNormal, TimerOverflow, TimerReload.
  - `phase[1:0]` counts clocks within the Overflow and Reload states.
- **Reads** (combinational):
  - 0xFF04: `counter[15:8]`
  - 0xFF05: `tima`
  - 0xFF06: `tma`
  - 0xFF07: `{5'b11111, tac}`
- **Write strobe:** `bus_selected & bus_write & t_cycle==3`. The write takes effect on that clk edge.
- **DIV write:** any data sets `counter <= 0`. The counter does not also increment on that edge.
- **TAC write:** `tac <= data[2:0]`.
- **Tick signal:** `tick = tac[2] & counter[sel]`, where `sel` is 9, 3, 5, 7 for `tac[1:0]` = 00, 01, 10, 11.
  - `tick_q` is the registered `tick`.
  - An increment fires on the edge where `tick_q==1 && tick==0`.
  - The same falling-edge rule applies when the fall is caused by a DIV or TAC write (hardware glitch reproduced).
- **Increment:** in TimerNormal only, `tima <= tima+1`. Increments in Overflow or Reload are dropped.
- **Overflow sequence:**
  - An increment from 0xFF sets `tima <= 0x00`, `state <= TimerOverflow`, `phase <= 0`.
  - TimerOverflow lasts 4 clks; `tima` reads 0x00.
  - On the 4th edge: `tima <= tma`, `timer_irq <= 1`, `state <= TimerReload`, `phase <= 0`.
  - TimerReload lasts 4 clks, then returns to TimerNormal.
- **TIMA write:**
  - TimerNormal: `tima <= data`. A write on the same edge as an increment wins over the increment.
  - TimerOverflow: `tima <= data`, `state <= TimerNormal`. The reload and the irq are cancelled.
  - TimerReload: ignored.
- **TMA write:** `tma <= data`. In TimerReload, also `tima <= data`.

## Timing
- **Reset values:** `counter` 0, `tima` 0, `tma` 0, `tac` 0, `tick_q` 0, `state` TimerNormal, `phase` 0, `timer_irq` 0. `bus_data_out` is 0xFF when not selected.
- Reset asserted mid-Overflow aborts the sequence; no irq is raised.
- **Tick latency:** `tima` changes 1 clk after `tick` falls. With `tac[1:0]`=01 the period is 16 clk.
- **Overflow timeline:**
  - Edge E: `tima` FF→00.
  - `tima` reads 00 for clks E..E+3.
  - Edge E+4: `tima` = `tma`, `timer_irq` goes high for exactly one clk.
  - Edges E+4..E+7: state is Reload.
  - From E+8: state is Normal.
- Register read data is combinational, available in the same cycle as `bus_addr`.

## Structure
- Shared package `gb_pkg` holds:
  - typedef `timer_state_e`
  - localparams `ADDR_DIV`, `ADDR_TIMA`, `ADDR_TMA`, `ADDR_TAC`
  - `TAC_READ_MASK` = 0xF8
- Single flat module; no sub-module is warranted.

## Test plan
- **DIV count and reset:** reset, then run 256 clk → DIV reads 0x01. Write 0x5A to 0xFF04 at `t_cycle`=3 → DIV 0x00 and `counter` 0.
- **Basic increment:** TAC=0x05, TIMA=0x00, run 160 clk → TIMA 0x0A. TAC reads 0xFD.
- **Overflow and reload:** TMA=0xAB, TIMA=0xFF, TAC=0x05 → TIMA reads 0x00 for 4 clk, then 0xAB. `timer_irq` is high exactly 1 clk.
- **Cancel in Overflow:** write TIMA=0x42 during TimerOverflow → TIMA 0x42, no irq, no reload.
- **Writes in Reload:** write TIMA=0x42 during TimerReload → TIMA stays 0xAB. Write TMA=0x77 during Reload → TIMA 0x77.
- **DIV glitch and reset abort:**
  - TAC=0x05 with `counter[3]`=1, write DIV → TIMA increments by 1.
  - Assert reset mid-Overflow → all registers return to 0 and no irq is raised.
